hex_word_entry: RTL and testbench

Manual 32-bit word entry for the board: the input-side counterpart of the seven-segment display path. Operator dials a hex digit on four switches, presses a digit key to shift it in, and presses a commit key to push the assembled word out through a valid/ready write port with an auto-incrementing address. The datapath (instruction/data memory loader) sits on the write port. `out_Word` is meant to feed the existing display mux so the operator sees the word while typing it.

---
 rtl/hex_entry_pkg.sv | 12 +
 rtl/key_debounce.sv | 48 ++++
 rtl/hex_word_entry.sv | 101 ++++++++++
 tb/tb_hex_word_entry.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the manual hex word entry block.
package hex_entry_pkg;

  typedef enum logic [0:0] {
    ENTRY = 1'b0,
    SEND  = 1'b1
  } entry_state_e;

  localparam int unsigned MAX_DIGITS = 8;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debouncer for an active-low push-button.
// Emits a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic in_Key,
  output logic out_Level,
  output logic out_Press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_Key;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        // Any sample matching the current level is a bounce: restart.
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_Level = level_q;
  assign out_Press = press_q;

endmodule

// File: rtl/hex_word_entry.sv
// Manual 32-bit word entry: shift in hex digits from switches, commit the word
// through a valid/ready write port with an auto-incrementing address.
module hex_word_entry
  import hex_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] BASE_ADDR       = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_KeyDigit,
  input  logic        in_KeyCommit,
  input  logic [3:0]  in_Nibble,
  input  logic        in_Ready,
  output logic [31:0] out_Word,
  output logic [3:0]  out_Digits,
  output logic        out_Valid,
  output logic [31:0] out_WrData,
  output logic [31:0] out_Addr
);

  logic digit_press, commit_press;
  logic digit_level, commit_level;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_digit (
    .clock    (clock),
    .reset    (reset),
    .in_Key   (in_KeyDigit),
    .out_Level(digit_level),
    .out_Press(digit_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_commit (
    .clock    (clock),
    .reset    (reset),
    .in_Key   (in_KeyCommit),
    .out_Level(commit_level),
    .out_Press(commit_press)
  );

  // Debounced levels are not needed here; only press edges drive entry.
  logic unused_levels;
  assign unused_levels = digit_level ^ commit_level;

  entry_state_e state_q;
  logic [31:0]  word_q;
  logic [3:0]   digits_q;
  logic         valid_q;
  logic [31:0]  wr_data_q;
  logic [31:0]  addr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ENTRY;
      word_q    <= '0;
      digits_q  <= '0;
      valid_q   <= 1'b0;
      wr_data_q <= '0;
      addr_q    <= BASE_ADDR;
    end else begin
      unique case (state_q)
        ENTRY: begin
          // Commit takes priority; a coincident digit press is dropped.
          if (commit_press) begin
            if (digits_q != '0) begin
              wr_data_q <= word_q;
              valid_q   <= 1'b1;
              state_q   <= SEND;
            end
          end else if (digit_press) begin
            word_q <= {word_q[27:0], in_Nibble};
            if (digits_q != 4'(MAX_DIGITS)) begin
              digits_q <= digits_q + 4'd1;
            end
          end
        end
        SEND: begin
          if (in_Ready) begin
            valid_q  <= 1'b0;
            addr_q   <= addr_q + ADDR_STEP;
            word_q   <= '0;
            digits_q <= '0;
            state_q  <= ENTRY;
          end
        end
        default: state_q <= ENTRY;
      endcase
    end
  end

  assign out_Word   = word_q;
  assign out_Digits = digits_q;
  assign out_Valid  = valid_q;
  assign out_WrData = wr_data_q;
  assign out_Addr   = addr_q;

endmodule

// File: tb/tb_hex_word_entry.sv
// Directed bench for hex_word_entry; two instances differ only in BASE_ADDR.
module tb_hex_word_entry;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_KeyDigit = 1'b1;
  logic        in_KeyCommit = 1'b1;
  logic [3:0]  in_Nibble = 4'h0;
  logic        in_Ready = 1'b0;

  logic [31:0] word0, wr_data0, addr0;
  logic [3:0]  digits0;
  logic        valid0;
  logic [31:0] word1, wr_data1, addr1;
  logic [3:0]  digits1;
  logic        valid1;

  int total = 0;
  int bad = 0;
  int digit_pulses = 0;
  int p0;

  always #5 clock = ~clock;

  hex_word_entry #(
    .DEBOUNCE_CYCLES(4),
    .BASE_ADDR      (32'h0)
  ) dut0 (
    .clock       (clock),
    .reset       (reset),
    .in_KeyDigit (in_KeyDigit),
    .in_KeyCommit(in_KeyCommit),
    .in_Nibble   (in_Nibble),
    .in_Ready    (in_Ready),
    .out_Word    (word0),
    .out_Digits  (digits0),
    .out_Valid   (valid0),
    .out_WrData  (wr_data0),
    .out_Addr    (addr0)
  );

  hex_word_entry #(
    .DEBOUNCE_CYCLES(4),
    .BASE_ADDR      (32'hFFFF_FFFC)
  ) dut1 (
    .clock       (clock),
    .reset       (reset),
    .in_KeyDigit (in_KeyDigit),
    .in_KeyCommit(in_KeyCommit),
    .in_Nibble   (in_Nibble),
    .in_Ready    (in_Ready),
    .out_Word    (word1),
    .out_Digits  (digits1),
    .out_Valid   (valid1),
    .out_WrData  (wr_data1),
    .out_Addr    (addr1)
  );

  always @(negedge clock) begin
    if (dut0.u_key_digit.out_Press) digit_pulses++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_KeyDigit  = 1'b1;
    in_KeyCommit = 1'b1;
    in_Ready     = 1'b0;
    reset        = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // Hold key low long enough for one press pulse, then release and settle.
  task automatic press(input bit commit, input logic [3:0] nib);
    in_Nibble = nib;
    if (commit) in_KeyCommit = 1'b0;
    else in_KeyDigit = 1'b0;
    repeat (8) tick();
    in_KeyDigit  = 1'b1;
    in_KeyCommit = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rst_word", word0, 32'h0);
    check("rst_digits", {28'h0, digits0}, 32'h0);
    check("rst_valid", {31'h0, valid0}, 32'h0);
    check("rst_wrdata", wr_data0, 32'h0);
    check("rst_addr0", addr0, 32'h0);
    check("rst_addr1", addr1, 32'hFFFF_FFFC);

    // Bounce rejection and press latency
    in_Nibble = 4'h5;
    p0 = digit_pulses;
    for (int i = 0; i < 10; i++) begin
      in_KeyDigit = i[0];
      repeat (2) tick();
    end
    check("bounce_no_pulse", digit_pulses - p0, 0);
    in_KeyDigit = 1'b0;
    repeat (5) tick();
    check("press_t5", {31'h0, dut0.u_key_digit.out_Press}, 32'h0);
    tick();
    check("press_t6", {31'h0, dut0.u_key_digit.out_Press}, 32'h1);
    tick();
    check("press_t7", {31'h0, dut0.u_key_digit.out_Press}, 32'h0);
    check("bounce_word", word0, 32'h5);
    in_KeyDigit = 1'b1;
    repeat (10) tick();
    check("bounce_one_pulse", digit_pulses - p0, 1);
    check("bounce_digits", {28'h0, digits0}, 32'h1);

    // Entry of eight digits, then saturating ninth
    do_reset();
    for (int n = 1; n <= 8; n++) press(1'b0, 4'(n));
    check("entry8_word", word0, 32'h1234_5678);
    check("entry8_digits", {28'h0, digits0}, 32'h8);
    press(1'b0, 4'h9);
    check("entry9_word", word0, 32'h2345_6789);
    check("entry9_digits", {28'h0, digits0}, 32'h8);

    // Handshake with back-pressure
    do_reset();
    press(1'b0, 4'hA);
    press(1'b0, 4'hB);
    in_KeyCommit = 1'b0;
    repeat (6) tick();
    check("commit_t6_valid", {31'h0, valid0}, 32'h0);
    tick();
    check("commit_t7_valid", {31'h0, valid0}, 32'h1);
    in_KeyCommit = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      check("hs_hold_valid", {31'h0, valid0}, 32'h1);
      check("hs_hold_data", wr_data0, 32'h0000_00AB);
      check("hs_hold_addr", addr0, 32'h0);
      tick();
    end
    in_Ready = 1'b1;
    tick();
    in_Ready = 1'b0;
    check("hs_done_valid", {31'h0, valid0}, 32'h0);
    check("hs_done_addr", addr0, 32'h4);
    check("hs_done_word", word0, 32'h0);
    check("hs_done_digits", {28'h0, digits0}, 32'h0);
    check("wrap_addr", addr1, 32'h0);
    check("wrap_valid", {31'h0, valid1}, 32'h0);

    // Commit with no digits is ignored
    do_reset();
    press(1'b1, 4'h0);
    check("empty_commit_valid", {31'h0, valid0}, 32'h0);

    // Digit press during SEND is discarded
    press(1'b0, 4'h3);
    press(1'b1, 4'h3);
    check("send_valid", {31'h0, valid0}, 32'h1);
    press(1'b0, 4'h5);
    check("send_word_kept", word0, 32'h3);
    check("send_data", wr_data0, 32'h3);
    in_Ready = 1'b1;
    tick();
    in_Ready = 1'b0;
    repeat (3) tick();
    check("send_word_clear", word0, 32'h0);
    check("send_digits_clear", {28'h0, digits0}, 32'h0);

    // Coincident digit and commit: commit wins
    do_reset();
    press(1'b0, 4'h7);
    in_Nibble    = 4'hC;
    in_KeyDigit  = 1'b0;
    in_KeyCommit = 1'b0;
    repeat (8) tick();
    in_KeyDigit  = 1'b1;
    in_KeyCommit = 1'b1;
    repeat (8) tick();
    check("both_valid", {31'h0, valid0}, 32'h1);
    check("both_data", wr_data0, 32'h7);
    check("both_word", word0, 32'h7);

    // Asynchronous reset mid-SEND
    reset = 1'b0;
    #1;
    check("arst_valid", {31'h0, valid0}, 32'h0);
    check("arst_wrdata", wr_data0, 32'h0);
    check("arst_word", word0, 32'h0);
    check("arst_digits", {28'h0, digits0}, 32'h0);
    check("arst_addr0", addr0, 32'h0);
    check("arst_addr1", addr1, 32'hFFFF_FFFC);
    tick();
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
